buffer_issue_writer: RTL and testbench
======================================

# buffer_issue_writer

Producer side of the memory-buffer / issue-counter handshake. Accepts image and filter words on two valid/ready streams and writes them into the shared 1024 x 18 buffer through one write port: image at 0-511, filter at 512-1023. Publishes monotonically increasing issue counters that the DSP controller compares against its own consumption counters. Applies backpressure so no unconsumed slot is ever overwritten.

## Interface
- DEPTH, 512: slots per buffer half; power of two; address wraps modulo DEPTH.
- DATA_W, 18: word width.
- CNT_W, 13: issue/consume counter width.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts a job from IDLE, ignored elsewhere.
- image_length  in  CNT_W  image words in the job; latched on start.
- filter_length  in  CNT_W  filter words in the job; latched on start.
- img_valid / img_ready  in / out  1  image stream handshake.
- img_data  in  DATA_W  image word.
- flt_valid / flt_ready  in / out  1  filter stream handshake.
- flt_data  in  DATA_W  filter word.
- wr_en  out  1  buffer write enable (registered).
- wr_addr  out  10  buffer write address (registered).
- wr_data  out  DATA_W  buffer write data (registered).
- issue_a_alloc_counter  out  CNT_W  image words committed to the buffer.
- filter_issue_counter  out  CNT_W  filter words committed.
- issue_a_dsp_counter  in  CNT_W  image words consumed by the DSP.
- filter_dsp_counter  in  CNT_W  filter words consumed.
- busy  out  1  high in FILL and WAIT.
- done  out  1  job complete; held until reset.

## Operation
- States:
  - IDLE: the reset state.
  - IDLE -> FILL on start. Latch both lengths, clear the internal issued counters img_iss / flt_iss.
  - FILL -> WAIT when img_iss == image_len and flt_iss == filter_len. Both lengths 0 passes through FILL in one cycle.
  - WAIT -> DONE when both published counters and both DSP counters equal the latched lengths.
  - DONE holds until reset. A new job requires rst, because the DSP counters only clear on reset.
- Eligibility, image side: state == FILL, img_iss < image_len, and (img_iss - issue_a_dsp_counter) mod 2^CNT_W < DEPTH. The filter side mirrors this with filter counters.
- Arbitration: single write port, at most one grant per cycle.
  - If only one side is eligible and valid, that side is granted.
  - If both are, grant the side holding priority, then pass priority to the other side.
  - Priority starts on image at reset.
- img_ready = image eligible and (no filter request or image holds priority); flt_ready likewise. Ready may depend on the other stream's valid. Transfer = valid && ready.
- On an image grant, register wr_addr = {0, img_iss[8:0]} and wr_data = img_data; img_iss increments. Filter grants use address {1, flt_iss[8:0]}.
- Counter widths: CNT_W-bit, modulo arithmetic. Lengths never exceed 2^CNT_W - 1.

## Timing
- Grant at edge N: wr_* is valid during cycle N+1, and the RAM commits at edge N+1.
- The matching published counter increments at edge N+1. The DSP never sees a count ahead of committed data.
- Back-to-back grants give one write per cycle. Peak throughput is 1 word/cycle combined across both streams.
- Reset values: wr_en 0, wr_addr 0, wr_data 0, both published counters 0, busy 0, done 0, img_ready 0, flt_ready 0. Priority resets to image.
- Reset mid-job: everything returns to reset values immediately (asynchronous). An in-flight write is dropped.
- Full condition (difference == DEPTH): ready stays low until the DSP counter advances. Re-admission happens the same cycle the DSP counter changes.
- done rises one cycle after the WAIT exit condition is true.

## Configuration
- ISSUE_WRITER_STATS_EN defined: adds output stall_cycles[15:0].
  - Counts FILL cycles in which a stream is valid but its ready is low because the buffer is full.
  - One count per cycle, even when both streams stall.
  - Saturates at 0xFFFF; resets to 0.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package: the state encoding (IDLE/FILL/WAIT/DONE), the image/filter half-select address bit constants, and the DEPTH/CNT_W defaults. The DSP controller uses the same definitions.
- One natural sub-module: issue_arbiter (two-request round-robin with eligibility inputs, producing grants and readies). The FSM, counters and write register stay in the top.

## Test plan
- Lengths 4/4, both streams always valid, DSP consuming immediately:
  - writes alternate image/filter at addresses 0, 512, 1, 513, ...
  - each counter reaches 4 one cycle after its last write
  - done rises after the DSP counters reach 4.
- Image length 600, DSP held at 0: exactly 512 image writes, then img_ready stays low. Advancing issue_a_dsp_counter to 1 admits one write, to address 0 (wrap).
- Grant at edge N: issue_a_alloc_counter changes at N+1, never earlier than the wr_en cycle.
- Lengths 0/0: start leads to done within 3 cycles with no wr_en.
- Assert rst mid-FILL with 100 words issued: all outputs return to reset values asynchronously; the job after release and start begins at address 0.
- With ISSUE_WRITER_STATS_EN: 10 full-stall cycles give stall_cycles == 10.

Source files
------------

// File: rtl/buffer_issue_writer_pkg.sv
// Shared definitions for the buffer / issue-counter handshake: FSM encoding,
// buffer half-select bits and default geometry (also used by the DSP controller).
package buffer_issue_writer_pkg;

    localparam int unsigned DefDepth = 512;
    localparam int unsigned DefDataW = 18;
    localparam int unsigned DefCntW  = 13;

    // MSB of the buffer address selects the half.
    localparam logic ImgHalf = 1'b0;
    localparam logic FltHalf = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWait,
        StDone
    } wr_state_e;

endpackage

// File: rtl/buffer_issue_writer_arbiter.sv
// Two-request round-robin for the single buffer write port. Priority only
// passes to the other side after a contended grant.
module buffer_issue_writer_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic img_elig,
    input  logic flt_elig,
    input  logic img_valid,
    input  logic flt_valid,
    output logic img_ready,
    output logic flt_ready,
    output logic img_grant,
    output logic flt_grant
);

    logic prio_flt_q;
    logic img_req;
    logic flt_req;

    assign img_req   = img_elig & img_valid;
    assign flt_req   = flt_elig & flt_valid;
    assign img_ready = img_elig & (~flt_req | ~prio_flt_q);
    assign flt_ready = flt_elig & (~img_req | prio_flt_q);
    assign img_grant = img_valid & img_ready;
    assign flt_grant = flt_valid & flt_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_flt_q <= 1'b0;
        end else if (img_req && flt_req) begin
            prio_flt_q <= ~prio_flt_q;
        end
    end

endmodule

// File: rtl/buffer_issue_writer.sv
// Producer side of the buffer / issue-counter handshake: writes image and filter
// streams into the shared buffer. Optional ISSUE_WRITER_STATS_EN adds stall_cycles.
module buffer_issue_writer
    import buffer_issue_writer_pkg::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        image_length,
    input  logic [CNT_W-1:0]        filter_length,
    input  logic                    img_valid,
    output logic                    img_ready,
    input  logic [DATA_W-1:0]       img_data,
    input  logic                    flt_valid,
    output logic                    flt_ready,
    input  logic [DATA_W-1:0]       flt_data,
    output logic                    wr_en,
    output logic [$clog2(DEPTH):0]  wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [CNT_W-1:0]        issue_a_alloc_counter,
    output logic [CNT_W-1:0]        filter_issue_counter,
    input  logic [CNT_W-1:0]        issue_a_dsp_counter,
    input  logic [CNT_W-1:0]        filter_dsp_counter,
    output logic                    busy,
    output logic                    done
`ifdef ISSUE_WRITER_STATS_EN
    ,
    output logic [15:0]             stall_cycles
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    wr_state_e state_q, state_d;

    logic [CNT_W-1:0]  img_len_q, flt_len_q;
    logic [CNT_W-1:0]  img_iss_q, flt_iss_q;
    logic [CNT_W-1:0]  img_pub_q, flt_pub_q;
    logic [CNT_W-1:0]  img_occ, flt_occ;
    logic              img_elig, flt_elig;
    logic              img_grant, flt_grant;
    logic              wr_en_q;
    logic [AW:0]       wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // Occupancy is modulo 2^CNT_W so it stays correct across counter wrap.
    assign img_occ  = img_iss_q - issue_a_dsp_counter;
    assign flt_occ  = flt_iss_q - filter_dsp_counter;
    assign img_elig = (state_q == StFill) && (img_iss_q < img_len_q) && (img_occ < DepthC);
    assign flt_elig = (state_q == StFill) && (flt_iss_q < flt_len_q) && (flt_occ < DepthC);

    buffer_issue_writer_arbiter u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .img_elig  (img_elig),
        .flt_elig  (flt_elig),
        .img_valid (img_valid),
        .flt_valid (flt_valid),
        .img_ready (img_ready),
        .flt_ready (flt_ready),
        .img_grant (img_grant),
        .flt_grant (flt_grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StFill;
            StFill: begin
                if ((img_iss_q == img_len_q) && (flt_iss_q == flt_len_q)) state_d = StWait;
            end
            StWait: begin
                if ((img_pub_q == img_len_q) && (flt_pub_q == flt_len_q) &&
                    (issue_a_dsp_counter == img_len_q) && (filter_dsp_counter == flt_len_q)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            img_len_q <= '0;
            flt_len_q <= '0;
            img_iss_q <= '0;
            flt_iss_q <= '0;
            img_pub_q <= '0;
            flt_pub_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && start) begin
                img_len_q <= image_length;
                flt_len_q <= filter_length;
                img_iss_q <= '0;
                flt_iss_q <= '0;
            end else begin
                if (img_grant) img_iss_q <= img_iss_q + CntOne;
                if (flt_grant) flt_iss_q <= flt_iss_q + CntOne;
            end

            wr_en_q <= img_grant | flt_grant;
            if (img_grant) begin
                wr_addr_q <= {ImgHalf, img_iss_q[AW-1:0]};
                wr_data_q <= img_data;
            end else if (flt_grant) begin
                wr_addr_q <= {FltHalf, flt_iss_q[AW-1:0]};
                wr_data_q <= flt_data;
            end

            // Publish only once the write is on the port, so the DSP never runs ahead.
            if (wr_en_q) begin
                if (wr_addr_q[AW] == ImgHalf) img_pub_q <= img_pub_q + CntOne;
                else                          flt_pub_q <= flt_pub_q + CntOne;
            end
        end
    end

    assign wr_en                 = wr_en_q;
    assign wr_addr               = wr_addr_q;
    assign wr_data               = wr_data_q;
    assign issue_a_alloc_counter = img_pub_q;
    assign filter_issue_counter  = flt_pub_q;
    assign busy                  = (state_q == StFill) || (state_q == StWait);
    assign done                  = (state_q == StDone);

`ifdef ISSUE_WRITER_STATS_EN
    logic [15:0] stall_q;
    logic        img_full, flt_full, stall_evt;

    assign img_full  = (state_q == StFill) && (img_iss_q < img_len_q) && (img_occ >= DepthC);
    assign flt_full  = (state_q == StFill) && (flt_iss_q < flt_len_q) && (flt_occ >= DepthC);
    assign stall_evt = (img_valid && img_full) || (flt_valid && flt_full);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (stall_evt && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_buffer_issue_writer.sv
// Scoreboard bench for buffer_issue_writer: accepted words queue their expected
// buffer writes, which are popped and compared whenever wr_en is seen.
module tb_buffer_issue_writer;

    localparam int CNT_W  = 13;
    localparam int DATA_W = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  image_length = '0, filter_length = '0;
    logic              img_valid = 1'b0, flt_valid = 1'b0;
    logic              img_ready, flt_ready;
    logic [DATA_W-1:0] img_data = '0, flt_data = '0;
    logic              wr_en;
    logic [9:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  issue_a_alloc_counter, filter_issue_counter;
    logic [CNT_W-1:0]  issue_a_dsp_counter = '0, filter_dsp_counter = '0;
    logic              busy, done;
`ifdef ISSUE_WRITER_STATS_EN
    logic [15:0]       stall_cycles;
`endif

    always #5 clk = ~clk;

    buffer_issue_writer dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .image_length          (image_length),
        .filter_length         (filter_length),
        .img_valid             (img_valid),
        .img_ready             (img_ready),
        .img_data              (img_data),
        .flt_valid             (flt_valid),
        .flt_ready             (flt_ready),
        .flt_data              (flt_data),
        .wr_en                 (wr_en),
        .wr_addr               (wr_addr),
        .wr_data               (wr_data),
        .issue_a_alloc_counter (issue_a_alloc_counter),
        .filter_issue_counter  (filter_issue_counter),
        .issue_a_dsp_counter   (issue_a_dsp_counter),
        .filter_dsp_counter    (filter_dsp_counter),
        .busy                  (busy),
        .done                  (done)
`ifdef ISSUE_WRITER_STATS_EN
        ,
        .stall_cycles          (stall_cycles)
`endif
    );

    typedef struct packed {
        logic [9:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  img_sent, flt_sent, img_tot, flt_tot;
    int  img_wr_seen = 0, flt_wr_seen = 0;
    bit  auto_push, dsp_follow;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] img_word(input int i);
        return DATA_W'(32'h1000 + i);
    endfunction

    function automatic logic [DATA_W-1:0] flt_word(input int i);
        return DATA_W'(32'h2000 + i);
    endfunction

    // Write monitor: every write must match the oldest expectation, and each
    // published counter must still lag during the write cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            img_wr_seen = 0;
            flt_wr_seen = 0;
        end else begin
            check_eq("img_counter", 32'(issue_a_alloc_counter), 32'(img_wr_seen));
            check_eq("flt_counter", 32'(filter_issue_counter), 32'(flt_wr_seen));
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_wr", 32'(exp_q.size()), 32'd1);
                    if (wr_addr[9]) flt_wr_seen++; else img_wr_seen++;
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check_eq("wr_data", 32'(wr_data), 32'(e.data));
                    if (e.addr[9]) flt_wr_seen++; else img_wr_seen++;
                end
            end
        end
    end

    task automatic cycle();
        bit ix, fx;
        @(negedge clk);
        ix = img_valid && img_ready;
        fx = flt_valid && flt_ready;
        @(posedge clk);
        #1;
        if (ix) begin
            if (auto_push) exp_q.push_back('{addr: {1'b0, img_sent[8:0]}, data: img_word(img_sent)});
            img_sent++;
        end
        if (fx) begin
            if (auto_push) exp_q.push_back('{addr: {1'b1, flt_sent[8:0]}, data: flt_word(flt_sent)});
            flt_sent++;
        end
        img_valid = (img_sent < img_tot);
        flt_valid = (flt_sent < flt_tot);
        img_data  = img_word(img_sent);
        flt_data  = flt_word(flt_sent);
        if (dsp_follow) begin
            issue_a_dsp_counter = issue_a_alloc_counter;
            filter_dsp_counter  = filter_issue_counter;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        img_valid = 1'b0;
        flt_valid = 1'b0;
        issue_a_dsp_counter = '0;
        filter_dsp_counter = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic start_job(input int il, input int fl, input bit follow, input bit push);
        img_tot = il;
        flt_tot = fl;
        img_sent = 0;
        flt_sent = 0;
        dsp_follow = follow;
        auto_push = push;
        issue_a_dsp_counter = '0;
        filter_dsp_counter = '0;
        image_length = CNT_W'(il);
        filter_length = CNT_W'(fl);
        img_data = img_word(0);
        flt_data = flt_word(0);
        img_valid = (il > 0);
        flt_valid = (fl > 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int n;

        // Reset values, with a valid stream pushing against the idle block
        rst = 1'b0;
        img_valid = 1'b1;
        flt_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_img_cnt", 32'(issue_a_alloc_counter), 32'd0);
        check_eq("rst_flt_cnt", 32'(filter_issue_counter), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_img_ready", 32'(img_ready), 32'd0);
        check_eq("rst_flt_ready", 32'(flt_ready), 32'd0);
`ifdef ISSUE_WRITER_STATS_EN
        check_eq("rst_stall", 32'(stall_cycles), 32'd0);
`endif

        // 4/4 job, both streams valid, DSP consuming at once: strict alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: 10'(i), data: img_word(i)});
            exp_q.push_back('{addr: 10'(512 + i), data: flt_word(i)});
        end
        start_job(4, 4, 1'b1, 1'b0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 60) begin
            cycle();
            n++;
        end
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("t1_img_cnt", 32'(issue_a_alloc_counter), 32'd4);
        check_eq("t1_flt_cnt", 32'(filter_issue_counter), 32'd4);
        check_eq("t1_dsp_img", 32'(issue_a_dsp_counter), 32'd4);
        check_eq("t1_busy_off", 32'(busy), 32'd0);

        // Image 600, DSP held at 0: 512 writes, then full until the DSP advances
        do_reset();
        start_job(600, 0, 1'b0, 1'b1);
        n = 0;
        while (img_sent < 512 && n < 700) begin
            cycle();
            n++;
        end
        check_eq("t2_fill_count", 32'(img_sent), 32'd512);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("t2_full_ready", 32'(img_ready), 32'd0);
        end
        check_eq("t2_writes", 32'(img_wr_seen), 32'd512);
`ifdef ISSUE_WRITER_STATS_EN
        check_eq("t2_stall_cycles", 32'(stall_cycles), 32'd10);
`endif
        issue_a_dsp_counter = 13'd1;
        #1;
        check_eq("t2_readmit", 32'(img_ready), 32'd1);
        cycle();
        cycle();
        cycle();
        check_eq("t2_wrap_writes", 32'(img_wr_seen), 32'd513);
        check_eq("t2_refull", 32'(img_ready), 32'd0);
        check_eq("t2_wrap_queue", 32'(exp_q.size()), 32'd0);

        // Zero-length job reaches done with no write
        do_reset();
        start_job(0, 0, 1'b1, 1'b1);
        n = 0;
        while (!done && n < 3) begin
            cycle();
            n++;
        end
        check_eq("t3_done", 32'(done), 32'd1);
        check_eq("t3_latency", 32'(n), 32'd2);
        check_eq("t3_no_writes", 32'(img_wr_seen + flt_wr_seen), 32'd0);

        // Asynchronous reset mid-fill, then a fresh job restarts at address 0
        do_reset();
        start_job(300, 0, 1'b0, 1'b1);
        n = 0;
        while (img_sent < 100 && n < 200) begin
            cycle();
            n++;
        end
        check_eq("t4_issued", 32'(img_sent), 32'd100);
        check_eq("t4_inflight", 32'(wr_en), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t4_wr_en", 32'(wr_en), 32'd0);
        check_eq("t4_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("t4_wr_data", 32'(wr_data), 32'd0);
        check_eq("t4_img_cnt", 32'(issue_a_alloc_counter), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_img_ready", 32'(img_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        start_job(3, 0, 1'b1, 1'b1);
        n = 0;
        while (!done && n < 30) begin
            cycle();
            n++;
        end
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_writes", 32'(img_wr_seen), 32'd3);
        check_eq("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
